// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port arbiter sharing one sdram access port
// Latches one request at a time, holds mem_enable until mem_ready or watchdog expiry.
module sdram_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [24:0] p0_addr,
  input  logic        p0_write,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_width,
  output logic [31:0] p0_rdata,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [24:0] p1_addr,
  input  logic        p1_write,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_width,
  output logic [31:0] p1_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic        mem_enable,
  output logic [24:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  // Counter value in the last permitted ACCESS cycle (counter is 0 in the first one).
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        grant, last_grant, timed_out, pick, req_any, expire;
  logic [15:0] cnt;

  assign req_any = p0_req | p1_req;
  assign expire  = (cnt == TO_LAST);

  always_comb begin
    pick = 1'b0;
    if (PRIO_MODE == 1)
      pick = !p0_req;
    else if (p0_req && p1_req)
      pick = !last_grant;
    else
      pick = !p0_req;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ACCESS;
      ACCESS:  if (mem_ready || expire) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      timed_out  <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_wdata  <= '0;
      mem_width  <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant     <= pick;
            mem_addr  <= pick ? p1_addr  : p0_addr;
            mem_write <= pick ? p1_write : p0_write;
            mem_wdata <= pick ? p1_wdata : p0_wdata;
            mem_width <= pick ? p1_width : p0_width;
            cnt       <= '0;
            timed_out <= 1'b0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 16'd1;
          // A ready arriving in the expiry cycle still counts as a normal completion.
          if (mem_ready) begin
            last_grant <= grant;
            timed_out  <= 1'b0;
            if (!mem_write) begin
              if (grant)
                p1_rdata <= mem_rdata;
              else
                p0_rdata <= mem_rdata;
            end
          end else if (expire) begin
            last_grant <= grant;
            timed_out  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_enable = (state == ACCESS);
    p0_ack     = (state == RELEASE) && !grant;
    p1_ack     = (state == RELEASE) && grant;
    p0_err     = p0_ack && timed_out;
    p1_err     = p1_ack && timed_out;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - bench for sdram_arbiter
// Instance 0: round-robin, instance 1: fixed priority; both TIMEOUT=8.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req [2];
  logic [24:0] p0_addr [2];
  logic        p0_write [2];
  logic [31:0] p0_wdata [2];
  logic [1:0]  p0_width [2];
  logic [31:0] p0_rdata [2];
  logic        p0_ack [2];
  logic        p0_err [2];
  logic        p1_req [2];
  logic [24:0] p1_addr [2];
  logic        p1_write [2];
  logic [31:0] p1_wdata [2];
  logic [1:0]  p1_width [2];
  logic [31:0] p1_rdata [2];
  logic        p1_ack [2];
  logic        p1_err [2];
  logic        mem_enable [2];
  logic [24:0] mem_addr [2];
  logic        mem_write [2];
  logic [31:0] mem_wdata [2];
  logic [1:0]  mem_width [2];
  logic [31:0] mem_rdata [2];
  logic        mem_ready [2];

  // Memory model: ready after lat cycles of enable, never when lat < 0.
  int          lat [2];
  logic [31:0] mdata [2];
  logic [7:0]  wcnt [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_arbiter #(.PRIO_MODE(g), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req[g]), .p0_addr(p0_addr[g]), .p0_write(p0_write[g]),
      .p0_wdata(p0_wdata[g]), .p0_width(p0_width[g]), .p0_rdata(p0_rdata[g]),
      .p0_ack(p0_ack[g]), .p0_err(p0_err[g]),
      .p1_req(p1_req[g]), .p1_addr(p1_addr[g]), .p1_write(p1_write[g]),
      .p1_wdata(p1_wdata[g]), .p1_width(p1_width[g]), .p1_rdata(p1_rdata[g]),
      .p1_ack(p1_ack[g]), .p1_err(p1_err[g]),
      .mem_enable(mem_enable[g]), .mem_addr(mem_addr[g]), .mem_write(mem_write[g]),
      .mem_wdata(mem_wdata[g]), .mem_width(mem_width[g]),
      .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g])
    );

    always @(posedge clk) begin
      if (rst || !mem_enable[g])
        wcnt[g] <= 8'd0;
      else
        wcnt[g] <= wcnt[g] + 8'd1;
    end

    assign mem_ready[g] = mem_enable[g] && (lat[g] >= 0) && (int'(wcnt[g]) == lat[g]);
    assign mem_rdata[g] = mdata[g];
  end

  typedef struct {
    int          d;
    logic        r0;
    logic        r1;
    logic        wr;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    int          lat;
    logic [31:0] mdata;
    int          eport;
    logic        eerr;
    logic [31:0] erd;
    int          ecyc;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_fields(input int d, input logic wr, input logic [24:0] a,
                            input logic [31:0] wd, input logic [1:0] w);
    p0_write[d] = wr; p0_addr[d] = a; p0_wdata[d] = wd; p0_width[d] = w;
    p1_write[d] = wr; p1_addr[d] = a; p1_wdata[d] = wd; p1_width[d] = w;
  endtask

  // Called at a negedge right after inputs change (cycle 0); returns at the ack negedge.
  task automatic wait_ack(input int d, output int port, output int cyc, output logic err,
                          output logic [31:0] rd, output logic en_ack, output logic both,
                          output logic [24:0] fa, output logic fw, output logic [31:0] fd,
                          output logic [1:0] fwid, output logic stable);
    logic seen;
    port = -1; cyc = 0; err = 1'b0; rd = '0; en_ack = 1'b0; both = 1'b0;
    fa = '0; fw = 1'b0; fd = '0; fwid = '0; stable = 1'b1; seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_enable[d]) begin
        if (!seen) begin
          fa = mem_addr[d]; fw = mem_write[d]; fd = mem_wdata[d]; fwid = mem_width[d];
          seen = 1'b1;
        end else if (fa !== mem_addr[d] || fw !== mem_write[d] ||
                     fd !== mem_wdata[d] || fwid !== mem_width[d]) begin
          stable = 1'b0;
        end
      end
      if (p0_ack[d] || p1_ack[d]) begin
        port   = p1_ack[d] ? 1 : 0;
        both   = p0_ack[d] && p1_ack[d];
        cyc    = n;
        err    = port == 1 ? p1_err[d] : p0_err[d];
        rd     = port == 1 ? p1_rdata[d] : p0_rdata[d];
        en_ack = mem_enable[d];
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int port, cyc;
    logic err, en_ack, both, fw, stable;
    logic [31:0] rd, fd;
    logic [24:0] fa;
    logic [1:0] fwid;

    vt[0]  = '{0, 1, 0, 0, 25'h0000100, 32'h0,  2'b10, 5,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 7};
    vt[1]  = '{0, 0, 1, 1, 25'h1FFFFFF, 32'hA5, 2'b00, 0,  32'hFFFFFFFF, 1, 0, 32'h5A5A0000, 2};
    vt[2]  = '{0, 0, 1, 0, 25'h00ABCDE, 32'h0,  2'b01, 2,  32'h12345678, 1, 0, 32'h12345678, 4};
    vt[3]  = '{0, 1, 1, 0, 25'h0000004, 32'h0,  2'b10, 1,  32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 3};
    vt[4]  = '{0, 1, 1, 0, 25'h0000008, 32'h0,  2'b10, 0,  32'h11112222, 1, 0, 32'h11112222, 2};
    vt[5]  = '{0, 1, 0, 0, 25'h0000010, 32'h0,  2'b10, -1, 32'h0BADBAD0, 0, 1, 32'hCAFEF00D, 9};
    vt[6]  = '{0, 0, 1, 0, 25'h0000020, 32'h0,  2'b11, 3,  32'h33334444, 1, 0, 32'h33334444, 5};
    vt[7]  = '{0, 1, 0, 1, 25'h0000030, 32'h5555AAAA, 2'b01, 7, 32'hFFFFFFFF, 0, 0, 32'hCAFEF00D, 9};
    vt[8]  = '{1, 1, 1, 0, 25'h0000040, 32'h0,  2'b10, 0,  32'h9999AAAA, 0, 0, 32'h9999AAAA, 2};
    vt[9]  = '{1, 0, 1, 0, 25'h0000044, 32'h0,  2'b10, 1,  32'hBBBB0001, 1, 0, 32'hBBBB0001, 3};
    vt[10] = '{1, 1, 1, 1, 25'h0000048, 32'h1234, 2'b10, 2, 32'hFFFFFFFF, 0, 0, 32'h9999AAAA, 4};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      p0_req[d] = 1'b0; p1_req[d] = 1'b0;
      set_fields(d, 1'b0, '0, '0, '0);
      lat[d] = -1; mdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_mem_enable", 32'(mem_enable[d]), 32'h0);
      check("reset_mem_addr", 32'(mem_addr[d]), 32'h0);
      check("reset_mem_wdata", mem_wdata[d], 32'h0);
      check("reset_acks", {30'h0, p1_ack[d], p0_ack[d]}, 32'h0);
      check("reset_errs", {30'h0, p1_err[d], p0_err[d]}, 32'h0);
      check("reset_rdata", p0_rdata[d] | p1_rdata[d], 32'h0);
    end
    rst = 1'b0;

    // Round-robin, both ports requesting continuously from reset.
    set_fields(0, 1'b0, 25'h0000200, '0, 2'b10);
    lat[0] = 0; mdata[0] = 32'h5A5A0000;
    p0_req[0] = 1'b1; p1_req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, port, cyc, err, rd, en_ack, both, fa, fw, fd, fwid, stable);
      check($sformatf("rr_grant_%0d", k), 32'(port), 32'(k % 2));
      check($sformatf("rr_single_ack_%0d", k), 32'(both), 32'h0);
    end
    p0_req[0] = 1'b0; p1_req[0] = 1'b0;
    @(negedge clk);

    // Fixed priority: port 1 starves until port 0 drops.
    set_fields(1, 1'b0, 25'h0000300, '0, 2'b10);
    lat[1] = 0; mdata[1] = 32'h77770000;
    p0_req[1] = 1'b1; p1_req[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, port, cyc, err, rd, en_ack, both, fa, fw, fd, fwid, stable);
      check($sformatf("prio_grant_%0d", k), 32'(port), 32'h0);
    end
    p0_req[1] = 1'b0;
    wait_ack(1, port, cyc, err, rd, en_ack, both, fa, fw, fd, fwid, stable);
    check("prio_after_drop", 32'(port), 32'h1);
    check("prio_after_drop_cyc", 32'(cyc), 32'h3);
    p1_req[1] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      set_fields(vt[i].d, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].width);
      lat[vt[i].d] = vt[i].lat; mdata[vt[i].d] = vt[i].mdata;
      p0_req[vt[i].d] = vt[i].r0; p1_req[vt[i].d] = vt[i].r1;
      wait_ack(vt[i].d, port, cyc, err, rd, en_ack, both, fa, fw, fd, fwid, stable);
      p0_req[vt[i].d] = 1'b0; p1_req[vt[i].d] = 1'b0;
      check($sformatf("v%0d_port", i), 32'(port), 32'(vt[i].eport));
      check($sformatf("v%0d_cycle", i), 32'(cyc), 32'(vt[i].ecyc));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].eerr));
      check($sformatf("v%0d_rdata", i), rd, vt[i].erd);
      check($sformatf("v%0d_enable_on_ack", i), 32'(en_ack), 32'h0);
      check($sformatf("v%0d_single_ack", i), 32'(both), 32'h0);
      check($sformatf("v%0d_mem_addr", i), 32'(fa), 32'(vt[i].addr));
      check($sformatf("v%0d_mem_write", i), 32'(fw), 32'(vt[i].wr));
      check($sformatf("v%0d_mem_wdata", i), fd, vt[i].wdata);
      check($sformatf("v%0d_mem_width", i), 32'(fwid), 32'(vt[i].width));
      check($sformatf("v%0d_fields_stable", i), 32'(stable), 32'h1);
      @(negedge clk);
    end

    // Reset during ACCESS: no ack, then first tie goes to port 0.
    set_fields(0, 1'b0, 25'h0000400, '0, 2'b10);
    lat[0] = -1; mdata[0] = 32'h0;
    p0_req[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_precond_enable", 32'(mem_enable[0]), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_enable", 32'(mem_enable[0]), 32'h0);
    check("rst_mid_ack", {30'h0, p1_ack[0], p0_ack[0]}, 32'h0);
    check("rst_mid_rdata", p0_rdata[0], 32'h0);
    rst = 1'b0;
    p0_req[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_no_late_ack", {30'h0, p1_ack[0], p0_ack[0]}, 32'h0);
    end
    lat[0] = 0; mdata[0] = 32'h600DF00D;
    p0_req[0] = 1'b1; p1_req[0] = 1'b1;
    wait_ack(0, port, cyc, err, rd, en_ack, both, fa, fw, fd, fwid, stable);
    p0_req[0] = 1'b0; p1_req[0] = 1'b0;
    check("rst_tie_port", 32'(port), 32'h0);
    check("rst_tie_rdata", rd, 32'h600DF00D);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
